vga_capture_rx: RTL and testbench

Receive-side counterpart of the graphics output stage. It samples the VGA pins the graphics pipeline drives: hsync, vsync and the 2-bit R/G/B channels. From the sync edges it recovers pixel coordinates, checks line and frame timing against 640x480@60 and reports lock. While locked it emits each visible pixel with its x/y position. It sits on the bench/loopback side: a self-check block for the board and a scoreboard front-end for the graphics testbenches.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_sync_edge.sv | 50 +++++
 rtl/vga_capture_rx.sv | 178 +++++++++++++++++
 tb/tb_vga_capture_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and receiver lock-state encoding
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rx_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - optional synchronizer (VGA_RX_SYNC_EN), sample register and rise detect for one active-low sync
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_rise
);

  logic samp_q, samp_d;
  logic prev_q, prev_d;

`ifdef VGA_RX_SYNC_EN
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_sync;
    sync_d = meta_q;
    samp_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end
`else
  always_comb samp_d = i_sync;
`endif

  always_comb prev_d = samp_q;

  // Both stages reset to the idle-high level so release cannot look like a deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = samp_q & ~prev_q;

endmodule

// File: rtl/vga_capture_rx.sv
// rtl/vga_capture_rx.sv - VGA pin receiver: timing recovery, lock FSM, visible pixel output; VGA_RX_SYNC_EN adds input synchronizers
module vga_capture_rx
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_BP        = VGA_H_BP,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_BP        = VGA_V_BP,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [1:0] i_red,
  input  logic [1:0] i_green,
  input  logic [1:0] i_blue,
  output logic       o_locked,
  output logic       o_pix_valid,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [5:0] o_pix,
  output logic       o_frame_start,
  output logic       o_err,
  output logic [9:0] o_line_len
);

  localparam logic [9:0]  HBP   = 10'(H_BP);
  localparam logic [9:0]  HEND  = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0]  HTOT  = 10'(H_TOTAL);
  localparam logic [9:0]  VBP   = 10'(V_BP);
  localparam logic [9:0]  VEND  = 10'(V_BP + V_ACTIVE);
  localparam logic [10:0] VTOT  = 11'(V_TOTAL);
  localparam logic [2:0]  LOCKN = 3'(LOCK_FRAMES);

  logic        h_rise, v_rise;
  logic [5:0]  pix_s_q, pix_s_d;
  logic [9:0]  hcnt_q, hcnt_d, hcnt_cur;
  logic [9:0]  line_q, line_d;
  logic [10:0] frame_cnt;
  logic        line_bad, frame_bad, in_win;
  rx_state_e   state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        hchk_q, hchk_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic        fs_q, fs_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  pix_q, pix_d;
  logic [9:0]  line_len_q, line_len_d;

  vga_sync_edge u_hsync (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_sync (i_hsync),
    .o_rise (h_rise)
  );

  vga_sync_edge u_vsync (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_sync (i_vsync),
    .o_rise (v_rise)
  );

`ifdef VGA_RX_SYNC_EN
  logic [5:0] pix_m1_q, pix_m1_d, pix_m2_q, pix_m2_d;

  always_comb begin
    pix_m1_d = {i_red, i_green, i_blue};
    pix_m2_d = pix_m1_q;
    pix_s_d  = pix_m2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_m1_q <= 6'd0;
      pix_m2_q <= 6'd0;
    end else begin
      pix_m1_q <= pix_m1_d;
      pix_m2_q <= pix_m2_d;
    end
  end
`else
  always_comb pix_s_d = {i_red, i_green, i_blue};
`endif

  always_comb begin
    // hcnt reads 0 in the rise cycle itself; the register holds the next value.
    hcnt_cur   = h_rise ? 10'd0 : hcnt_q;
    hcnt_d     = sat_inc10(hcnt_cur);
    line_d     = v_rise ? 10'd0 : (h_rise ? sat_inc10(line_q) : line_q);
    frame_cnt  = {1'b0, line_q} + {10'd0, h_rise};
    line_bad   = h_rise && hchk_q && (hcnt_q != HTOT);
    frame_bad  = v_rise && (frame_cnt != VTOT);
    line_len_d = h_rise ? hcnt_q : line_len_q;

    state_d = state_q;
    good_d  = good_q;
    hchk_d  = hchk_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        good_d = 3'd0;
        hchk_d = 1'b0;
        if (v_rise) state_d = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        if (h_rise) hchk_d = 1'b1;
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          good_d  = 3'd0;
          hchk_d  = 1'b0;
          err_d   = 1'b1;
        end else if (v_rise && (state_q == ACQUIRE)) begin
          good_d = good_q + 3'd1;
          if (good_d == LOCKN) state_d = LOCKED;
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);
    in_win   = (hcnt_cur >= HBP) && (hcnt_cur < HEND) && (line_d >= VBP) && (line_d < VEND);
    valid_d  = locked_d && in_win;
    fs_d     = valid_d && (hcnt_cur == HBP) && (line_d == VBP);
    x_d      = valid_d ? hcnt_cur - HBP : x_q;
    y_d      = valid_d ? line_d - VBP : y_q;
    pix_d    = valid_d ? pix_s_q : pix_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_s_q    <= 6'd0;
      hcnt_q     <= 10'd0;
      line_q     <= 10'd0;
      state_q    <= SEARCH;
      good_q     <= 3'd0;
      hchk_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      pix_q      <= 6'd0;
      line_len_q <= 10'd0;
    end else begin
      pix_s_q    <= pix_s_d;
      hcnt_q     <= hcnt_d;
      line_q     <= line_d;
      state_q    <= state_d;
      good_q     <= good_d;
      hchk_q     <= hchk_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      line_len_q <= line_len_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_err         = err_q;
  assign o_pix_valid   = valid_q;
  assign o_frame_start = fs_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_pix         = pix_q;
  assign o_line_len    = line_len_q;

endmodule

// File: tb/tb_vga_capture_rx.sv
// tb/tb_vga_capture_rx.sv - scoreboard bench for vga_capture_rx on a reduced 8x4 raster
module tb_vga_capture_rx;

  localparam int HA = 8;
  localparam int HB = 3;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int VB = 2;
  localparam int VT = 10;
`ifdef VGA_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_hsync, i_vsync;
  logic [1:0] i_red, i_green, i_blue;
  logic       o_locked, o_pix_valid, o_frame_start, o_err;
  logic [9:0] o_x, o_y, o_line_len;
  logic [5:0] o_pix;

  typedef struct {
    int         x;
    int         y;
    logic [5:0] pix;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;
  int fs_seen = 0;
  int err_seen = 0;
  int push_cnt = 0;
  int fs_exp = 0;
  int err_exp = 0;
  int m_state = 0;
  int m_good = 0;
  int prev_lines = 0;
  int frame_no = 0;
  bit prev_vlow = 1'b0;

  vga_capture_rx #(
    .H_ACTIVE(HA), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BP(VB), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_hsync       (i_hsync),
    .i_vsync       (i_vsync),
    .i_red         (i_red),
    .i_green       (i_green),
    .i_blue        (i_blue),
    .o_locked      (o_locked),
    .o_pix_valid   (o_pix_valid),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_pix         (o_pix),
    .o_frame_start (o_frame_start),
    .o_err         (o_err),
    .o_line_len    (o_line_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_err) begin
        err_seen++;
        check("err_unlocks", o_locked, 0);
      end
      if (o_pix_valid) begin
        vcount++;
        if (o_frame_start) fs_seen++;
        check("pix_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("pix_x", o_x, e.x);
          check("pix_y", o_y, e.y);
          check("pix_rgb", o_pix, e.pix);
          check("pix_latency", cyc - e.cyc, LAT);
          check("pix_fs", o_frame_start, (e.x == 0 && e.y == 0));
        end
      end else begin
        check("fs_outside", o_frame_start, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_valid"}, o_pix_valid, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_pix"}, o_pix, 0);
    check({tag, "_fs"}, o_frame_start, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_linelen"}, o_line_len, 0);
  endtask

  // Frame-start model event runs first: the previous frame's vsync low lines make a rise here.
  task automatic drive_frame(input int nlines, input int stretch, input int rst_line, input int mode);
    int len;
    bit vis;
    logic [5:0] c;
    frame_no++;
    if (prev_vlow) begin
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (prev_lines == VT) begin
            m_good++;
            if (m_good == 2) m_state = 2;
          end else begin
            m_state = 0; m_good = 0; err_exp++;
          end
        end
        default: begin
          if (prev_lines != VT) begin m_state = 0; m_good = 0; err_exp++; end
        end
      endcase
    end
    push_cnt = 0;
    fs_exp = 0;
    for (int v = 0; v < nlines; v++) begin
      len = (v == stretch) ? HT + 1 : HT;
      if (v > 0 && v - 1 == stretch && m_state != 0) begin
        m_state = 0; m_good = 0; err_exp++;
      end
      if (v == rst_line) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        m_state = 0;
        m_good = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      for (int h = 0; h < len; h++) begin
        @(posedge clk);
        #1;
        i_hsync = (h < len - 2);
        i_vsync = (v < nlines - 2);
        vis = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
        c = (mode == 1) ? 6'h3F : 6'((h * 5) + (v * 11) + frame_no);
        if (!vis) c = 6'h15;
        {i_red, i_green, i_blue} = c;
        if (vis && m_state == 2) begin
          sb.push_back('{x: h - HB, y: v - VB, pix: c, cyc: cyc});
          push_cnt++;
          if (h == HB && v == VB) fs_exp++;
        end
      end
    end
    prev_vlow = 1'b1;
    prev_lines = nlines;
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_locked"}, o_locked, (m_state == 2));
    check({tag, "_errs"}, err_seen, err_exp);
    check({tag, "_nvalid"}, vcount, push_cnt);
    check({tag, "_nfs"}, fs_seen, fs_exp);
    check({tag, "_sb_empty"}, sb.size(), 0);
    vcount = 0;
    fs_seen = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_hsync = 1'b1;
    i_vsync = 1'b1;
    {i_red, i_green, i_blue} = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    drive_frame(VT, -1, -1, 0); end_checks("f1");
    drive_frame(VT, -1, -1, 0); end_checks("f2");
    drive_frame(VT, -1, -1, 0); end_checks("f3");
    check("f3_not_locked", o_locked, 0);
    drive_frame(VT, -1, -1, 0); end_checks("f4");
    check("f4_lock", o_locked, 1);
    check("f4_npix", push_cnt, HA * VA);
    check("f4_linelen", o_line_len, HT);

    drive_frame(VT, -1, -1, 1); end_checks("white");
    check("white_last_x", o_x, HA - 1);
    check("white_last_y", o_y, VA - 1);
    check("white_hold_pix", o_pix, 6'h3F);

    drive_frame(VT, 8, -1, 0); end_checks("stretch");
    check("stretch_linelen", o_line_len, HT + 1);
    check("stretch_unlock", o_locked, 0);
    drive_frame(VT, -1, -1, 0); end_checks("re1");
    drive_frame(VT, -1, -1, 0); end_checks("re2");
    drive_frame(VT, -1, -1, 0); end_checks("re3");
    check("relock", o_locked, 1);

    drive_frame(VT, -1, 4, 0); end_checks("rstframe");
    drive_frame(VT, -1, -1, 0); end_checks("rs1");
    drive_frame(VT, -1, -1, 0); end_checks("rs2");
    drive_frame(VT, -1, -1, 0); end_checks("rs3");
    check("rst_relock", o_locked, 1);

    drive_frame(VT - 1, -1, -1, 0); end_checks("shortlk");
    drive_frame(VT, -1, -1, 0); end_checks("s1");
    drive_frame(VT, -1, -1, 0); end_checks("s2");
    drive_frame(VT - 1, -1, -1, 0); end_checks("shortacq");
    drive_frame(VT, -1, -1, 0); end_checks("s3");
    check("shortacq_search", o_locked, 0);
    drive_frame(VT, -1, -1, 0); end_checks("s4");
    drive_frame(VT, -1, -1, 0); end_checks("s5");
    check("good_cleared", o_locked, 0);
    drive_frame(VT, -1, -1, 0); end_checks("s6");
    check("final_lock", o_locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
